// File: rtl/game_pkg.sv
// Shared types for the whack-a-mole game-flow controller: state codes and sound codes.
package game_pkg;

    // Game states; encodings are visible on the state output.
    typedef enum logic [2:0] {
        StReady      = 3'd1,
        StPlaying    = 3'd2,
        StGameOver   = 3'd3,
        StStageClear = 3'd4,
        StGameClear  = 3'd5,
        StCountdown  = 3'd6
    } game_state_e;

    // Sound codes handed to the sound player.
    typedef enum logic [2:0] {
        SndNone       = 3'd0,
        SndBeep       = 3'd1,
        SndStart      = 3'd2,
        SndHit        = 3'd3,
        SndMiss       = 3'd4,
        SndStageClear = 3'd5,
        SndGameOver   = 3'd6,
        SndGameClear  = 3'd7
    } snd_mode_e;

    // Decrement that holds at zero.
    function automatic logic [6:0] sat_dec7(input logic [6:0] v);
        return (v == 7'd0) ? 7'd0 : v - 7'd1;
    endfunction

    function automatic logic [3:0] sat_dec4(input logic [3:0] v);
        return (v == 4'd0) ? 4'd0 : v - 4'd1;
    endfunction

endpackage

// File: rtl/snd_req_arb.sv
// Sound request arbiter: latches the newest request and issues it as a one-cycle
// pulse on the first cycle the sound player is idle.
module snd_req_arb
    import game_pkg::*;
(
    input  logic       clk_1mhz,
    input  logic       rst,
    input  logic       i_req,
    input  logic [2:0] i_mode,
    input  logic       i_snd_busy,
    output logic       o_snd_req,
    output logic [2:0] o_snd_mode,
    output logic       o_pending
);

    logic       r_pending;
    logic [2:0] r_pend_mode;
    logic       r_snd_req;
    logic [2:0] r_snd_mode;

    logic       w_have;
    logic [2:0] w_mode;
    logic       w_issue;

    // A request arriving this cycle overrides whatever is still pending.
    always_comb begin
        w_have  = i_req | r_pending;
        w_mode  = i_req ? i_mode : r_pend_mode;
        w_issue = w_have & ~i_snd_busy;
    end

    // Pending latch plus registered request pulse and held mode.
    always_ff @(posedge clk_1mhz) begin
        if (rst) begin
            r_pending   <= 1'b0;
            r_pend_mode <= SndNone;
            r_snd_req   <= 1'b0;
            r_snd_mode  <= SndNone;
        end else begin
            r_snd_req <= w_issue;
            if (w_issue) begin
                r_snd_mode <= w_mode;
            end
            r_pending <= w_have & i_snd_busy;
            if (w_have) begin
                r_pend_mode <= w_mode;
            end
        end
    end

    assign o_snd_req  = r_snd_req;
    assign o_snd_mode = r_snd_mode;
    assign o_pending  = r_pending;

endmodule

// File: rtl/game_flow_ctrl.sv
// Whack-a-mole game-flow controller: sequences countdown, play, stage/game end,
// scores hits against N_MOLES mole channels and requests sounds through snd_req_arb.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int unsigned N_HOLES        = 8,
    parameter int unsigned N_MOLES        = 2,
    parameter int unsigned N_STAGES       = 3,
    parameter int unsigned LIVES          = 3,
    parameter int unsigned STAGE_SECS     = 30,
    parameter int unsigned COUNTDOWN_SECS = 3,
    parameter int unsigned SCORE_W        = 10,
    parameter int unsigned START_KEY      = 10
) (
    input  logic                 clk_1mhz,
    input  logic                 rst,
    input  logic                 sec_tick,
    input  logic                 btn_pressed,
    input  logic [3:0]           btn_value,
    input  logic [4*N_MOLES-1:0] mole_pos,
    input  logic                 snd_busy,
    output logic                 snd_req,
    output logic [2:0]           snd_mode,
    output logic [2:0]           state,
    output logic [3:0]           stage,
    output logic [3:0]           lives,
    output logic [6:0]           timer,
    output logic                 timer_running,
    output logic                 mole_enable,
    output logic [N_MOLES-1:0]   hit_mask,
    output logic [SCORE_W-1:0]   score,
    output logic [SCORE_W-1:0]   high_score,
    output logic                 high_score_updated
);

    localparam logic [3:0] HolesMax  = 4'(N_HOLES);
    localparam logic [3:0] StageLast = 4'(N_STAGES);
    localparam logic [3:0] LivesInit = 4'(LIVES);
    localparam logic [6:0] StageSecs = 7'(STAGE_SECS);
    localparam logic [6:0] CdSecs    = 7'(COUNTDOWN_SECS);
    localparam logic [3:0] StartKey  = 4'(START_KEY);

    game_state_e r_state;
    game_state_e w_state_d;

    logic               r_btn_prev;
    logic [3:0]         r_stage;
    logic [3:0]         r_lives;
    logic [6:0]         r_timer;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_high_score;
    logic               r_hs_upd;
    logic [N_MOLES-1:0] r_hit_mask;

    logic [3:0]         w_stage_d;
    logic [3:0]         w_lives_d;
    logic [6:0]         w_timer_d;
    logic [SCORE_W-1:0] w_score_d;
    logic [SCORE_W-1:0] w_hs_d;
    logic               w_hs_upd_d;
    logic [N_MOLES-1:0] w_hit_mask_d;

    logic               w_press;
    logic               w_start;
    logic               w_valid_key;
    logic [N_MOLES-1:0] w_match;
    logic               w_hit;
    logic               w_miss;
    logic [SCORE_W:0]   w_score_sum;
    logic [SCORE_W-1:0] w_score_add;

    logic               w_req;
    snd_mode_e          w_req_mode;
    logic               w_arb_pending;

    // Key decode: press edge, start key, hole-range check and per-channel match.
    always_comb begin
        w_press     = btn_pressed & ~r_btn_prev;
        w_start     = w_press && (btn_value == StartKey);
        w_valid_key = w_press && (btn_value != 4'd0) && (btn_value <= HolesMax);
        for (int k = 0; k < int'(N_MOLES); k++) begin
            // Empty channels read 0, which no valid key can equal.
            w_match[k] = (mole_pos[4*k +: 4] == btn_value);
        end
        w_hit       = w_valid_key && (|w_match);
        w_miss      = w_valid_key && !(|w_match);
        w_score_sum = {1'b0, r_score} + (SCORE_W + 1)'(r_stage);
        w_score_add = w_score_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_score_sum[SCORE_W-1:0];
    end

    // State register.
    always_ff @(posedge clk_1mhz) begin
        if (rst) begin
            r_state <= StReady;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next state and sound request; end-of-play sounds override the hit/miss sound.
    always_comb begin
        w_state_d  = r_state;
        w_req      = 1'b0;
        w_req_mode = SndNone;
        case (r_state)
            StReady: begin
                if (w_start) begin
                    w_state_d = StCountdown;
                end
            end
            StCountdown: begin
                if (sec_tick) begin
                    w_req = 1'b1;
                    if (r_timer > 7'd1) begin
                        w_req_mode = SndBeep;
                    end else begin
                        w_req_mode = SndStart;
                        w_state_d  = StPlaying;
                    end
                end
            end
            StPlaying: begin
                if (w_hit) begin
                    w_req      = 1'b1;
                    w_req_mode = SndHit;
                end else if (w_miss) begin
                    w_req      = 1'b1;
                    w_req_mode = SndMiss;
                end
                if (w_miss && (r_lives <= 4'd1)) begin
                    w_state_d  = StGameOver;
                    w_req      = 1'b1;
                    w_req_mode = SndGameOver;
                end else if (sec_tick && (r_timer <= 7'd1)) begin
                    w_req = 1'b1;
                    if (r_stage < StageLast) begin
                        w_state_d  = StStageClear;
                        w_req_mode = SndStageClear;
                    end else begin
                        w_state_d  = StGameClear;
                        w_req_mode = SndGameClear;
                    end
                end
            end
            StStageClear: begin
                // Entry request is either pending or pulsing; leave once both are done.
                if (!w_arb_pending && !snd_req && !snd_busy) begin
                    w_state_d = StReady;
                end
            end
            StGameOver, StGameClear: begin
                if (w_start) begin
                    w_state_d = StReady;
                end
            end
            default: w_state_d = StReady;
        endcase
    end

    // Output decode from the state register.
    always_comb begin
        state         = r_state;
        timer_running = (r_state == StCountdown) || (r_state == StPlaying);
        mole_enable   = (r_state == StPlaying);
    end

    // Datapath next values: timer, lives, score, stage and high score.
    always_comb begin
        w_stage_d    = r_stage;
        w_lives_d    = r_lives;
        w_timer_d    = r_timer;
        w_score_d    = r_score;
        w_hs_d       = r_high_score;
        w_hs_upd_d   = r_hs_upd;
        w_hit_mask_d = '0;
        case (r_state)
            StReady: begin
                if (w_start) begin
                    w_timer_d = CdSecs;
                end
            end
            StCountdown: begin
                if (sec_tick) begin
                    w_timer_d = (r_timer > 7'd1) ? r_timer - 7'd1 : StageSecs;
                end
            end
            StPlaying: begin
                if (w_hit) begin
                    w_hit_mask_d = w_match;
                    w_score_d    = w_score_add;
                end
                if (w_miss) begin
                    w_lives_d = sat_dec4(r_lives);
                end
                if (sec_tick) begin
                    w_timer_d = sat_dec7(r_timer);
                end
                // Compare against the score including any hit landing this cycle.
                if ((w_state_d == StGameOver) || (w_state_d == StGameClear)) begin
                    if (w_score_d > r_high_score) begin
                        w_hs_d     = w_score_d;
                        w_hs_upd_d = 1'b1;
                    end
                end
            end
            StStageClear: begin
                if (w_state_d == StReady) begin
                    w_stage_d = r_stage + 4'd1;
                end
            end
            StGameOver, StGameClear: begin
                if (w_start) begin
                    w_stage_d  = 4'd1;
                    w_lives_d  = LivesInit;
                    w_score_d  = '0;
                    w_hs_upd_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk_1mhz) begin
        if (rst) begin
            r_btn_prev   <= 1'b0;
            r_stage      <= 4'd1;
            r_lives      <= LivesInit;
            r_timer      <= 7'd0;
            r_score      <= '0;
            r_high_score <= '0;
            r_hs_upd     <= 1'b0;
            r_hit_mask   <= '0;
        end else begin
            r_btn_prev   <= btn_pressed;
            r_stage      <= w_stage_d;
            r_lives      <= w_lives_d;
            r_timer      <= w_timer_d;
            r_score      <= w_score_d;
            r_high_score <= w_hs_d;
            r_hs_upd     <= w_hs_upd_d;
            r_hit_mask   <= w_hit_mask_d;
        end
    end

    assign stage              = r_stage;
    assign lives              = r_lives;
    assign timer              = r_timer;
    assign score              = r_score;
    assign high_score         = r_high_score;
    assign high_score_updated = r_hs_upd;
    assign hit_mask           = r_hit_mask;

    snd_req_arb u_snd_req_arb (
        .clk_1mhz   (clk_1mhz),
        .rst        (rst),
        .i_req      (w_req),
        .i_mode     (w_req_mode),
        .i_snd_busy (snd_busy),
        .o_snd_req  (snd_req),
        .o_snd_mode (snd_mode),
        .o_pending  (w_arb_pending)
    );

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with default parameters.
module tb_game_flow_ctrl;

    logic       clk_1mhz = 1'b0;
    logic       rst = 1'b1;
    logic       sec_tick = 1'b0;
    logic       btn_pressed = 1'b0;
    logic [3:0] btn_value = 4'd0;
    logic [7:0] mole_pos = 8'd0;
    logic       snd_busy = 1'b0;

    logic       snd_req;
    logic [2:0] snd_mode;
    logic [2:0] state;
    logic [3:0] stage;
    logic [3:0] lives;
    logic [6:0] timer;
    logic       timer_running;
    logic       mole_enable;
    logic [1:0] hit_mask;
    logic [9:0] score;
    logic [9:0] high_score;
    logic       high_score_updated;

    int n_tests;
    int n_fail;
    int cnt;
    logic [2:0] seen_mode;

    game_flow_ctrl u_dut (
        .clk_1mhz           (clk_1mhz),
        .rst                (rst),
        .sec_tick           (sec_tick),
        .btn_pressed        (btn_pressed),
        .btn_value          (btn_value),
        .mole_pos           (mole_pos),
        .snd_busy           (snd_busy),
        .snd_req            (snd_req),
        .snd_mode           (snd_mode),
        .state              (state),
        .stage              (stage),
        .lives              (lives),
        .timer              (timer),
        .timer_running      (timer_running),
        .mole_enable        (mole_enable),
        .hit_mask           (hit_mask),
        .score              (score),
        .high_score         (high_score),
        .high_score_updated (high_score_updated)
    );

    always #5 clk_1mhz = ~clk_1mhz;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_1mhz);
        #1;
    endtask

    // Guarantees one low sample before the press so every call is a fresh edge.
    task automatic press_key(input logic [3:0] v);
        @(negedge clk_1mhz);
        @(negedge clk_1mhz);
        btn_value   = v;
        btn_pressed = 1'b1;
        @(posedge clk_1mhz);
        #1;
        btn_pressed = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk_1mhz);
        sec_tick = 1'b1;
        @(posedge clk_1mhz);
        #1;
        sec_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic press_tick(input logic [3:0] v);
        @(negedge clk_1mhz);
        @(negedge clk_1mhz);
        btn_value   = v;
        btn_pressed = 1'b1;
        sec_tick    = 1'b1;
        @(posedge clk_1mhz);
        #1;
        btn_pressed = 1'b0;
        sec_tick    = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 20 && state != 3'd1; i++) step(1);
        check_eq(tag, 32'(state), 1);
    endtask

    task automatic start_stage();
        press_key(4'd10);
        ticks(3);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_state"}, 32'(state), 1);
        check_eq({tag, "_stage"}, 32'(stage), 1);
        check_eq({tag, "_lives"}, 32'(lives), 3);
        check_eq({tag, "_timer"}, 32'(timer), 0);
        check_eq({tag, "_score"}, 32'(score), 0);
        check_eq({tag, "_hs"}, 32'(high_score), 0);
        check_eq({tag, "_hs_upd"}, 32'(high_score_updated), 0);
        check_eq({tag, "_snd_req"}, 32'(snd_req), 0);
        check_eq({tag, "_snd_mode"}, 32'(snd_mode), 0);
        check_eq({tag, "_hit_mask"}, 32'(hit_mask), 0);
        check_eq({tag, "_trun"}, 32'(timer_running), 0);
        check_eq({tag, "_mole_en"}, 32'(mole_enable), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        step(2);
        check_reset_values("rst");
        @(negedge clk_1mhz);
        rst = 1'b0;

        // READY ignores non-start keys, START enters COUNTDOWN.
        press_key(4'd5);
        check_eq("ready_ignore", 32'(state), 1);
        press_key(4'd10);
        check_eq("cd_state", 32'(state), 6);
        check_eq("cd_timer3", 32'(timer), 3);
        check_eq("cd_trun", 32'(timer_running), 1);
        tick();
        check_eq("cd_timer2", 32'(timer), 2);
        check_eq("cd_req1", 32'(snd_req), 1);
        check_eq("cd_mode1", 32'(snd_mode), 1);
        tick();
        check_eq("cd_timer1", 32'(timer), 1);
        check_eq("cd_mode1b", 32'(snd_mode), 1);
        tick();
        check_eq("play_timer", 32'(timer), 30);
        check_eq("play_state", 32'(state), 2);
        check_eq("play_mode2", 32'(snd_mode), 2);
        check_eq("play_mole_en", 32'(mole_enable), 1);

        // Stage 1 single-channel hit, then out-of-range keys ignored.
        mole_pos = {4'd0, 4'd3};
        press_key(4'd3);
        check_eq("hit1_mask", 32'(hit_mask), 1);
        check_eq("hit1_score", 32'(score), 1);
        check_eq("hit1_mode", 32'(snd_mode), 3);
        step(1);
        check_eq("hit1_mask_clr", 32'(hit_mask), 0);
        press_key(4'd0);
        check_eq("key0_lives", 32'(lives), 3);
        press_key(4'd9);
        check_eq("key9_lives", 32'(lives), 3);
        check_eq("key9_score", 32'(score), 1);

        // Stage 1 expiry -> STAGE_CLEAR -> READY with stage 2.
        ticks(29);
        check_eq("s1_timer1", 32'(timer), 1);
        tick();
        check_eq("sc_state", 32'(state), 4);
        check_eq("sc_req", 32'(snd_req), 1);
        check_eq("sc_mode", 32'(snd_mode), 5);
        wait_ready("sc_to_ready");
        check_eq("sc_stage2", 32'(stage), 2);

        // Stage 2 hit on both channels scores the stage value once.
        start_stage();
        check_eq("s2_state", 32'(state), 2);
        check_eq("s2_timer", 32'(timer), 30);
        mole_pos = {4'd4, 4'd4};
        press_key(4'd4);
        check_eq("hit2_mask", 32'(hit_mask), 3);
        check_eq("hit2_score", 32'(score), 3);
        check_eq("hit2_mode", 32'(snd_mode), 3);
        step(1);
        check_eq("hit2_mask_clr", 32'(hit_mask), 0);

        // Busy gating: hit then miss while busy, only the miss sound goes out.
        @(negedge clk_1mhz);
        snd_busy = 1'b1;
        press_key(4'd4);
        check_eq("busy_hit_noreq", 32'(snd_req), 0);
        check_eq("busy_hit_score", 32'(score), 5);
        press_key(4'd7);
        check_eq("busy_miss_noreq", 32'(snd_req), 0);
        check_eq("busy_miss_lives", 32'(lives), 2);
        cnt = 0;
        repeat (46) begin
            step(1);
            if (snd_req) cnt++;
        end
        check_eq("busy_window_reqs", 32'(cnt), 0);
        @(negedge clk_1mhz);
        snd_busy  = 1'b0;
        cnt       = 0;
        seen_mode = 3'd0;
        repeat (10) begin
            step(1);
            if (snd_req) begin
                cnt++;
                seen_mode = snd_mode;
            end
        end
        check_eq("after_busy_reqs", 32'(cnt), 1);
        check_eq("after_busy_mode", 32'(seen_mode), 4);

        // Last-life miss in the expiry cycle wins: GAME_OVER.
        press_key(4'd7);
        check_eq("miss_lives1", 32'(lives), 1);
        ticks(29);
        check_eq("s2_timer1", 32'(timer), 1);
        press_tick(4'd7);
        check_eq("go_lives", 32'(lives), 0);
        check_eq("go_state", 32'(state), 3);
        check_eq("go_hs", 32'(high_score), 5);
        check_eq("go_hs_upd", 32'(high_score_updated), 1);
        check_eq("go_req", 32'(snd_req), 1);
        check_eq("go_mode", 32'(snd_mode), 6);
        tick();
        check_eq("go_tick_state", 32'(state), 3);
        check_eq("go_tick_score", 32'(score), 5);
        press_key(4'd10);
        check_eq("restart_state", 32'(state), 1);
        check_eq("restart_stage", 32'(stage), 1);
        check_eq("restart_lives", 32'(lives), 3);
        check_eq("restart_score", 32'(score), 0);
        check_eq("restart_hs_upd", 32'(high_score_updated), 0);
        check_eq("restart_hs", 32'(high_score), 5);

        // Play through to stage 3 and finish the game.
        start_stage();
        ticks(30);
        wait_ready("g2_s1_ready");
        check_eq("g2_stage2", 32'(stage), 2);
        start_stage();
        ticks(30);
        wait_ready("g2_s2_ready");
        check_eq("g2_stage3", 32'(stage), 3);
        start_stage();
        mole_pos = {4'd0, 4'd6};
        press_key(4'd6);
        press_key(4'd6);
        check_eq("s3_score6", 32'(score), 6);
        ticks(29);
        check_eq("s3_timer1", 32'(timer), 1);
        press_tick(4'd6);
        check_eq("gc_score", 32'(score), 9);
        check_eq("gc_state", 32'(state), 5);
        check_eq("gc_hs", 32'(high_score), 9);
        check_eq("gc_hs_upd", 32'(high_score_updated), 1);
        check_eq("gc_mode", 32'(snd_mode), 7);
        cnt = snd_req ? 1 : 0;
        repeat (10) begin
            step(1);
            if (snd_req) cnt++;
        end
        check_eq("gc_one_req", 32'(cnt), 1);
        press_key(4'd10);
        check_eq("gc_restart_state", 32'(state), 1);
        check_eq("gc_restart_stage", 32'(stage), 1);
        check_eq("gc_restart_lives", 32'(lives), 3);
        check_eq("gc_restart_score", 32'(score), 0);

        // Score saturation at stage 1.
        start_stage();
        mole_pos = {4'd0, 4'd2};
        repeat (1023) press_key(4'd2);
        check_eq("sat_score_max", 32'(score), 1023);
        press_key(4'd2);
        check_eq("sat_score_hold", 32'(score), 1023);
        check_eq("sat_hit_mask", 32'(hit_mask), 1);

        // Reset mid-PLAYING with a sound still pending.
        @(negedge clk_1mhz);
        snd_busy = 1'b1;
        press_key(4'd5);
        check_eq("pre_rst_lives", 32'(lives), 2);
        @(negedge clk_1mhz);
        rst = 1'b1;
        step(1);
        check_reset_values("midrst");
        @(negedge clk_1mhz);
        rst      = 1'b0;
        snd_busy = 1'b0;
        cnt      = 0;
        repeat (10) begin
            step(1);
            if (snd_req) cnt++;
        end
        check_eq("rst_abort_snd", 32'(cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
